obi_data_mem_responder: RTL and testbench

Single-port OBI data-memory responder: the slave end of the core's data memory interface (req/gnt/rvalid/we/be/addr/wdata/rdata). It accepts requests from the core LSU, performs byte-enabled writes and full-word reads on an internal word-addressed array, and returns responses after a fixed pipelined latency. It sits beside the core top in the fullchip and is the data-side memory model for both RTL simulation and on-chip scratch use. Grant wait states are configurable.

---
 rtl/obi_data_mem_responder_if.sv | 21 ++
 rtl/obi_data_mem_responder.sv | 106 ++++++++++
 tb/tb_obi_data_mem_responder.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/obi_data_mem_responder_if.sv
// OBI data-side request/response bundle between the core LSU (master) and a memory (slave).
interface obi_data_mem_responder_if;
  logic        data_req_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;

  modport master (
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_rdata_o
  );

  modport slave (
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_rdata_o
  );
endinterface

// File: rtl/obi_data_mem_responder.sv
// Single-port OBI data-memory responder: byte-enabled writes, full-word reads,
// configurable grant wait states and a fixed RESP_LAT response pipeline.
// Optional macro OBI_RESP_RANDOM_STALL_EN: per-request pseudo-random grant stall
// drawn from a 16-bit Galois LFSR, bounded by GNT_STALL.
module obi_data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RESP_LAT   = 1,
  parameter int unsigned GNT_STALL  = 0
) (
  input logic                      clk_i,
  input logic                      rst_ni,
  obi_data_mem_responder_if.slave  bus
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned NBYTES = 4;

  logic [ADDR_WIDTH-1:0] w_idx;
  logic                  w_gnt;
  logic                  w_rd;
  logic [CNT_W-1:0]      w_load;
  logic                  w_unused_addr;

  logic [CNT_W-1:0]      r_stall_cnt;
  logic [DATA_W-1:0]     r_mem   [DEPTH];
  logic                  r_valid [RESP_LAT];
  logic [DATA_W-1:0]     r_rdata [RESP_LAT];

`ifdef OBI_RESP_RANDOM_STALL_EN
  localparam logic [15:0]      LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0]      LFSR_TAPS = 16'hB400;
  localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(32'(LFSR_SEED[2:0]) % (GNT_STALL + 1));

  logic [15:0] r_lfsr;

  // Free-running LFSR supplying the per-request stall draw
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign w_load = CNT_W'(32'(r_lfsr[2:0]) % (GNT_STALL + 1));
`else
  localparam logic [CNT_W-1:0] RST_LOAD = CNT_W'(GNT_STALL);

  assign w_load = RST_LOAD;
`endif

  // Word select ignores the byte offset and everything above the array, so addresses alias
  assign w_idx         = bus.data_addr_i[ADDR_WIDTH+1:2];
  assign w_unused_addr = ^{bus.data_addr_i[31:ADDR_WIDTH+2], bus.data_addr_i[1:0]};

  // Grant is combinational from req so a zero stall grants in the request cycle
  assign w_gnt          = rst_ni && bus.data_req_i && (r_stall_cnt == '0);
  assign w_rd           = w_gnt && !bus.data_we_i;
  assign bus.data_gnt_o = w_gnt;

  // Stall counter: reload when idle or on grant, count down while a request waits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stall_cnt <= RST_LOAD;
    end else if (!bus.data_req_i || w_gnt) begin
      r_stall_cnt <= w_load;
    end else begin
      r_stall_cnt <= r_stall_cnt - CNT_W'(1);
    end
  end

  // Byte-enabled write at the grant edge; contents survive reset
  always_ff @(posedge clk_i) begin
    if (w_gnt && bus.data_we_i) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (bus.data_be_i[b]) begin
          r_mem[w_idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Response pipeline: stage 0 captures the grant and read word, later stages shift
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < RESP_LAT; i++) begin
        r_valid[i] <= 1'b0;
        r_rdata[i] <= '0;
      end
    end else begin
      r_valid[0] <= w_gnt;
      r_rdata[0] <= w_rd ? r_mem[w_idx] : '0;
      for (int unsigned i = 1; i < RESP_LAT; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_rdata[i] <= r_rdata[i-1];
      end
    end
  end

  assign bus.data_rvalid_o = r_valid[RESP_LAT-1];
  assign bus.data_rdata_o  = r_rdata[RESP_LAT-1];

endmodule

// File: tb/tb_obi_data_mem_responder.sv
// Bench for obi_data_mem_responder: three instances with different latency/stall
// settings, a directed vector table, hand sequences for pipelining, stalls and
// reset, and a randomized phase checked cycle by cycle against a transaction model.
module tb_obi_data_mem_responder;

  localparam int NDUT = 3;
  localparam int unsigned LAT_0 = 1, LAT_1 = 3, LAT_2 = 2;
  localparam int unsigned STALL_0 = 0, STALL_1 = 0, STALL_2 = 2;

  int lat   [NDUT] = '{LAT_0, LAT_1, LAT_2};
  int stall [NDUT] = '{STALL_0, STALL_1, STALL_2};

  logic clk = 1'b0;
  logic rst_n;

  logic        req    [NDUT];
  logic        we     [NDUT];
  logic [3:0]  be     [NDUT];
  logic [31:0] addr   [NDUT];
  logic [31:0] wdata  [NDUT];
  logic        gnt    [NDUT];
  logic        rvalid [NDUT];
  logic [31:0] rdata  [NDUT];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  obi_data_mem_responder_if bus0 ();
  obi_data_mem_responder_if bus1 ();
  obi_data_mem_responder_if bus2 ();

  assign bus0.data_req_i = req[0];   assign bus0.data_we_i = we[0];   assign bus0.data_be_i = be[0];
  assign bus0.data_addr_i = addr[0]; assign bus0.data_wdata_i = wdata[0];
  assign gnt[0] = bus0.data_gnt_o;   assign rvalid[0] = bus0.data_rvalid_o; assign rdata[0] = bus0.data_rdata_o;
  assign bus1.data_req_i = req[1];   assign bus1.data_we_i = we[1];   assign bus1.data_be_i = be[1];
  assign bus1.data_addr_i = addr[1]; assign bus1.data_wdata_i = wdata[1];
  assign gnt[1] = bus1.data_gnt_o;   assign rvalid[1] = bus1.data_rvalid_o; assign rdata[1] = bus1.data_rdata_o;
  assign bus2.data_req_i = req[2];   assign bus2.data_we_i = we[2];   assign bus2.data_be_i = be[2];
  assign bus2.data_addr_i = addr[2]; assign bus2.data_wdata_i = wdata[2];
  assign gnt[2] = bus2.data_gnt_o;   assign rvalid[2] = bus2.data_rvalid_o; assign rdata[2] = bus2.data_rdata_o;

  obi_data_mem_responder #(.ADDR_WIDTH(10), .RESP_LAT(LAT_0), .GNT_STALL(STALL_0))
    u_dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(bus0));
  obi_data_mem_responder #(.ADDR_WIDTH(10), .RESP_LAT(LAT_1), .GNT_STALL(STALL_1))
    u_dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));
  obi_data_mem_responder #(.ADDR_WIDTH(10), .RESP_LAT(LAT_2), .GNT_STALL(STALL_2))
    u_dut2 (.clk_i(clk), .rst_ni(rst_n), .bus(bus2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          k;
    int          due;
    logic [31:0] data;
    bit          known;
  } resp_t;

  logic [31:0] m_mem   [NDUT][1024];
  bit          m_known [NDUT][1024];
  int          m_wait  [NDUT];
  resp_t       m_q     [$];

  // Per-cycle prediction: grant after `stall` waiting cycles, response `lat` cycles later
  always @(negedge clk) begin : monitor
    bit          eg, ev, ek;
    logic [31:0] ed;
    int          w;
    for (int k = 0; k < NDUT; k++) begin
      if (!rst_n) begin
        m_wait[k] = 0;
        for (int i = m_q.size() - 1; i >= 0; i--) if (m_q[i].k == k) m_q.delete(i);
        chk($sformatf("rst_gnt%0d", k), 32'(gnt[k]), 32'd0);
        chk($sformatf("rst_rvalid%0d", k), 32'(rvalid[k]), 32'd0);
        chk($sformatf("rst_rdata%0d", k), rdata[k], 32'd0);
      end else begin
        eg = req[k] && (m_wait[k] >= stall[k]);
        ev = 1'b0; ek = 1'b0; ed = '0;
        foreach (m_q[i]) begin
          if (m_q[i].k == k && m_q[i].due == cyc) begin
            ev = 1'b1; ed = m_q[i].data; ek = m_q[i].known;
          end
        end
        chk($sformatf("mon_gnt%0d@%0d", k, cyc), 32'(gnt[k]), 32'(eg));
        chk($sformatf("mon_rvalid%0d@%0d", k, cyc), 32'(rvalid[k]), 32'(ev));
        if (ev && ek) chk($sformatf("mon_rdata%0d@%0d", k, cyc), rdata[k], ed);
        for (int i = m_q.size() - 1; i >= 0; i--)
          if (m_q[i].k == k && m_q[i].due <= cyc) m_q.delete(i);
        if (eg) begin
          w = int'((addr[k] >> 2) % 1024);
          if (we[k]) begin
            for (int b = 0; b < 4; b++)
              if (be[k][b]) m_mem[k][w][8*b +: 8] = wdata[k][8*b +: 8];
            if (be[k] == 4'hF) m_known[k][w] = 1'b1;
            m_q.push_back('{k: k, due: cyc + lat[k], data: 32'd0, known: 1'b1});
          end else begin
            m_q.push_back('{k: k, due: cyc + lat[k], data: m_mem[k][w], known: m_known[k][w]});
          end
          m_wait[k] = 0;
        end else if (req[k]) begin
          m_wait[k] = m_wait[k] + 1;
        end else begin
          m_wait[k] = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Single transaction: hold req until grant, check wait count, then the response
  task automatic txn(input int k, input bit w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] d, input int exp_wait, input logic [31:0] exp_rd,
                     input string nm);
    int n;
    bit got;
    req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wdata[k] = d;
    n = 0; got = 1'b0;
    while (!got && n <= 20) begin
      @(negedge clk);
      if (gnt[k]) got = 1'b1;
      else begin
        n++;
        @(posedge clk); #1;
      end
    end
    if (!got) begin
      chk({nm, "_gnt_timeout"}, 32'd0, 32'd1);
      req[k] = 1'b0;
      return;
    end
    chk({nm, "_gnt_wait"}, 32'(n), 32'(exp_wait));
    @(posedge clk); #1;
    req[k] = 1'b0;
    for (int i = 1; i < lat[k]; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({nm, "_rvalid"}, 32'(rvalid[k]), 32'd1);
    chk({nm, "_rdata"}, rdata[k], exp_rd);
    @(posedge clk); #1;
  endtask

  // Random OBI traffic on one instance, occasionally abandoning a pending request
  task automatic rand_run(input int k, input int n);
    bit pend;
    bit written [8];
    int j;
    pend = 1'b0; j = 0;
    foreach (written[i]) written[i] = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (!pend || $urandom_range(0, 9) == 0) begin
        req[k] = ($urandom_range(0, 3) != 0);
        j = $urandom_range(0, 7);
        if (!written[j]) begin
          we[k] = 1'b1; be[k] = 4'hF;
        end else begin
          we[k] = 1'($urandom_range(0, 1)); be[k] = 4'($urandom);
        end
        addr[k]  = ($urandom & 32'hFFFF_F000) | 32'((512 + j) * 4) | ($urandom & 32'h3);
        wdata[k] = $urandom;
      end
      @(negedge clk);
      pend = req[k] && !gnt[k];
      if (req[k] && gnt[k] && we[k] && be[k] == 4'hF) written[j] = 1'b1;
      @(posedge clk); #1;
    end
    req[k] = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int          k;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_wait;
    logic [31:0] exp_rd;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];

  logic [31:0] bb_addr [4];
  logic [31:0] bb_data [4];

  initial begin
    tbl[0]  = '{0, 1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0};
    tbl[1]  = '{0, 1'b0, 4'h0, 32'h0000_0100, 32'h0,         0, 32'hDEAD_BEEF};
    tbl[2]  = '{0, 1'b1, 4'hF, 32'h0000_0200, 32'h1122_3344, 0, 32'h0};
    tbl[3]  = '{0, 1'b1, 4'h5, 32'h0000_0200, 32'hAABB_CCDD, 0, 32'h0};
    tbl[4]  = '{0, 1'b0, 4'hF, 32'h0000_0200, 32'h0,         0, 32'h11BB_33DD};
    tbl[5]  = '{0, 1'b1, 4'h0, 32'h0000_0200, 32'hFFFF_FFFF, 0, 32'h0};
    tbl[6]  = '{0, 1'b0, 4'h0, 32'h0000_0200, 32'h0,         0, 32'h11BB_33DD};
    tbl[7]  = '{0, 1'b1, 4'hF, 32'h0000_1004, 32'hCAFE_F00D, 0, 32'h0};
    tbl[8]  = '{0, 1'b0, 4'h0, 32'h0000_0004, 32'h0,         0, 32'hCAFE_F00D};
    tbl[9]  = '{0, 1'b0, 4'h0, 32'h0000_0006, 32'h0,         0, 32'hCAFE_F00D};
    tbl[10] = '{2, 1'b1, 4'hF, 32'h0000_0040, 32'h0102_0304, 2, 32'h0};
    tbl[11] = '{2, 1'b0, 4'h0, 32'h0000_0040, 32'h0,         2, 32'h0102_0304};
    tbl[12] = '{1, 1'b1, 4'hF, 32'h0000_0300, 32'hA1A1_A1A1, 0, 32'h0};
    tbl[13] = '{1, 1'b1, 4'hF, 32'h0000_0304, 32'hB2B2_B2B2, 0, 32'h0};
    tbl[14] = '{1, 1'b1, 4'hF, 32'h0000_0308, 32'hC3C3_C3C3, 0, 32'h0};
    tbl[15] = '{1, 1'b1, 4'hF, 32'h0000_030C, 32'hD4D4_D4D4, 0, 32'h0};
    tbl[16] = '{1, 1'b0, 4'h0, 32'h0000_0300, 32'h0,         0, 32'hA1A1_A1A1};
    bb_addr = '{32'h300, 32'h304, 32'h308, 32'h30C};
    bb_data = '{32'hA1A1_A1A1, 32'hB2B2_B2B2, 32'hC3C3_C3C3, 32'hD4D4_D4D4};

    for (int k = 0; k < NDUT; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; be[k] = 4'h0; addr[k] = '0; wdata[k] = '0;
    end
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++)
      txn(tbl[i].k, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata,
          tbl[i].exp_wait, tbl[i].exp_rd, $sformatf("vec%0d", i));

    // Four back-to-back reads on the 3-cycle pipeline
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'h0; addr[1] = bb_addr[i];
      end else begin
        req[1] = 1'b0;
      end
      @(negedge clk);
      chk($sformatf("b2b_gnt%0d", i), 32'(gnt[1]), 32'(i < 4));
      chk($sformatf("b2b_rvalid%0d", i), 32'(rvalid[1]), 32'(i >= 3 && i <= 6));
      if (i >= 3 && i <= 6) chk($sformatf("b2b_rdata%0d", i), rdata[1], bb_data[i-3]);
      @(posedge clk); #1;
    end

    // Held request with stall 2: grants land in the 3rd and 6th cycles
    req[2] = 1'b1; we[2] = 1'b0; be[2] = 4'h0; addr[2] = 32'h40;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("stall_gnt%0d", i), 32'(gnt[2]), 32'(i == 2 || i == 5));
      @(posedge clk); #1;
    end
    req[2] = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end

    // Reset pulse with two reads in flight on the 3-cycle pipeline
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h304;
    @(negedge clk);
    chk("rstseq_gnt0", 32'(gnt[1]), 32'd1);
    @(posedge clk); #1;
    addr[1] = 32'h308;
    @(negedge clk);
    chk("rstseq_gnt1", 32'(gnt[1]), 32'd1);
    @(posedge clk); #1;
    req[1] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rstseq_norv%0d", i), 32'(rvalid[1]), 32'd0);
      @(posedge clk); #1;
    end
    txn(1, 1'b0, 4'h0, 32'h308, 32'h0, 0, 32'hC3C3_C3C3, "rstseq_persist");

    // Randomized traffic on every instance
    for (int k = 0; k < NDUT; k++) rand_run(k, 400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
